pulse_gen_glitchfree: RTL
=========================

Name: pulse_gen_glitchfree

Overview:
- Output-side companion to the input deglitch filter.
- Converts single-cycle trigger requests into clean output pulses with a guaranteed minimum high time and minimum low time.
- A downstream 4-sample deglitch filter on the same or a faster clock never rejects a pulse and never merges two pulses.
- Triggers that arrive while a pulse or gap is in progress are counted and replayed in order, one pulse per trigger, until the pending counter saturates.

Parameters:
MIN_HIGH  4  output high time in clocks per pulse (>=1; >=4 when driving a 4-sample deglitcher)
MIN_LOW   4  output low time in clocks after every pulse (>=1)
CNT_W     8  width of internal high/low timer (2^CNT_W > max(MIN_HIGH, MIN_LOW))
PEND_W    4  width of pending-trigger counter (max pending = 2^PEND_W-1)

Ports:
clock     in   1       single system clock, all logic on rising edge
reset     in   1       synchronous, active-high reset
trig      in   1       request one pulse; sampled every clock, each high cycle is one request
clr_ovf   in   1       clears the overflow flag
out       out  1       registered glitch-free pulse output
busy      out  1       high when state != IDLE or pending != 0
pending   out  PEND_W  count of queued, not-yet-started pulses
overflow  out  1       sticky: a trigger was dropped because pending was full

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled high at an edge) forces the following, regardless of state, including mid-pulse:
  - out=0, pending=0, overflow=0, state=IDLE, timer=0.
  - trig during reset is discarded.
  - The output may therefore be truncated by reset; reset is the only permitted exception to the MIN_HIGH/MIN_LOW guarantees.
- States: IDLE, HIGH, GAP. out is a register: 1 only in HIGH.
- IDLE:
  - trig=1 at edge N -> state=HIGH, out=1 from edge N (visible cycle N+1). One-cycle latency.
  - timer loaded with MIN_HIGH-1.
- HIGH:
  - timer decrements each clock; at timer==0 -> state=GAP, out=0, timer loaded with MIN_LOW-1.
  - out is high for exactly MIN_HIGH cycles.
- GAP:
  - timer decrements; at timer==0:
    - if pending>0 or trig=1 -> state=HIGH, out=1, timer=MIN_HIGH-1. If pending>0, pending decrements, and the current trig is queued as below.
    - else -> IDLE.
  - out is low for exactly MIN_LOW cycles between back-to-back pulses; no extra dead cycle.
- Queuing:
  - trig=1 in HIGH or GAP, or in the GAP-exit cycle when a pulse is already being started from pending, increments pending.
  - A simultaneous increment and decrement leaves pending unchanged.
  - trig in the GAP-exit cycle with pending==0 starts the pulse directly; pending stays 0.
- Saturation:
  - trig when pending==2^PEND_W-1 and no decrement occurs that cycle -> trigger dropped, pending unchanged, overflow=1 next cycle.
  - overflow holds until clr_ovf=1 or reset.
  - clr_ovf and a new drop in the same cycle -> overflow=1 (set wins).
- Ordering: every accepted trigger yields exactly one pulse. Total pulses = triggers minus drops.
- Parameter sizing: timer width CNT_W; MIN_HIGH/MIN_LOW must fit. Pending arithmetic is unsigned, with no wrap (saturating).
- busy and pending are combinational from registers only; out is a pure flop output with no glitch path.

Test Plan:
- Single trig at cycle 10 (defaults) -> out=1 cycles 11–14, out=0 from 15; busy=1 cycles 11–18, busy=0 at 19; pending stays 0.
- trig high continuously for 3 cycles (10–12) -> pending goes 1, 2; three pulses:
  - out high 11–14, 19–22, 27–30; each low gap exactly 4 cycles.
  - pending 0 after cycle 26.
- Overflow, PEND_W=2: 6 trigs on consecutive cycles -> first pulse starts, pending saturates at 3, 2 triggers dropped.
  - overflow=1, exactly 4 pulses emitted.
  - clr_ovf pulse -> overflow=0.
- Trig landing on the last GAP cycle with pending=0 -> next pulse starts immediately, with low time exactly MIN_LOW (4 cycles); pending remains 0.
- Reset asserted on the 2nd high cycle of a pulse with pending=2 -> next cycle out=0, pending=0, busy=0, overflow=0; no further pulses; a fresh trig afterwards gives a normal 4-cycle pulse.
- Drive out into the 4-sample deglitch filter on the same clock with random trig bursts (10k cycles):
  - filtered output pulse count equals triggers minus drops;
  - every filtered pulse is high >=1 cycle;
  - no two pulses merge.

Source files
------------

// File: rtl/pulse_gen_glitchfree.sv
// Purpose: turns single-cycle trigger requests into clean output pulses, each high for
//          exactly MIN_HIGH clocks and followed by exactly MIN_LOW low clocks. Triggers
//          that arrive while a pulse or gap is running are queued and replayed in order.
// Latency: a trigger seen in IDLE raises out_o on the next clock (one-cycle latency).
// Backpressure: none upstream; the queue saturates at 2^PEND_W-1 and further triggers are
//          dropped and flagged on the sticky overflow_o.
// Ports:
//   clock_i    single system clock, rising edge
//   reset_i    synchronous, active-high reset (may truncate a pulse in flight)
//   trig_i     one pulse request per high cycle
//   clr_ovf_i  clears overflow_o (a drop in the same cycle wins)
//   out_o      registered pulse output, high only in HIGH
//   busy_o     state != IDLE or pending != 0
//   pending_o  queued, not-yet-started pulses
//   overflow_o sticky: a trigger was dropped because the queue was full
module pulse_gen_glitchfree #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4,
    parameter int CNT_W    = 8,
    parameter int PEND_W   = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              trig_i,
    input  logic              clr_ovf_i,
    output logic              out_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(MIN_LOW - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              out_q, out_d;
    logic              ovf_q, ovf_d;
    logic              pend_inc, pend_dec, drop;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;

        case (state_q)
            IDLE: begin
                // The queue is always empty here, so a trigger starts a pulse directly.
                if (trig_i) begin
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
                end
            end
            HIGH: begin
                pend_inc = trig_i;
                if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = LOW_LOAD;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (timer_q != '0) begin
                    pend_inc = trig_i;
                    timer_d  = timer_q - CNT_W'(1);
                end else if (pend_q != '0) begin
                    // Replay the oldest queued request; a trigger now joins the back of
                    // the queue so ordering is preserved.
                    state_d  = HIGH;
                    timer_d  = HIGH_LOAD;
                    pend_dec = 1'b1;
                    pend_inc = trig_i;
                end else if (trig_i) begin
                    // Empty queue: the trigger starts the next pulse with no dead cycle.
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Saturating queue: simultaneous increment and decrement cancel out.
        pend_d = pend_q;
        drop   = 1'b0;
        if (pend_inc && !pend_dec) begin
            if (pend_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

        ovf_d = drop | (ovf_q & ~clr_ovf_i);

        // The output is the registered image of the next state, so it has no
        // combinational path to any input.
        out_d = (state_d == HIGH);
    end

    assign out_o      = out_q;
    assign overflow_o = ovf_q;
    assign pending_o  = pend_q;
    assign busy_o     = (state_q != IDLE) || (pend_q != '0);

endmodule
